// File: rtl/dmem_rd_sched.sv
// dmem_rd_sched: two-port round-robin burst read scheduler for the image-data ROM.
// Port 0 is the scalar load unit, port 1 the vector load unit. Beats are
// registered into a single response slot with a valid/ready handshake.
// Optional feature macro: DMEM_RD_SCHED_PERF_EN (grant/stall performance counters).
module dmem_rd_sched #(
  parameter  int unsigned V         = 192,
  parameter  int unsigned AW        = 18,
  parameter  int unsigned SIZE      = 150000,
  parameter  int unsigned BURST_MAX = 8,
  localparam int unsigned LW        = $clog2(BURST_MAX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][AW-1:0]    req_addr,
  input  logic [1:0][LW-1:0]    req_len,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_vecop,
  input  logic [V-1:0]          rom_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [V-1:0]          rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic [31:0]           perf_gnt0,
  output logic [31:0]           perf_gnt1,
  output logic [31:0]           perf_stall
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic           last_gnt;   // port granted most recently (reset to 1 so port 0 has priority)
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  beat;
  logic           win;
  logic           hs;
  logic           issue;
  logic           oor;

  // Round-robin winner and request accept; ready is only offered while idle
  always_comb begin
    win       = req_valid[1];
    req_ready = 2'b00;
    if (req_valid == 2'b11) win = ~last_gnt;
    if ((state == IDLE) && (req_valid != 2'b00)) req_ready[win] = 1'b1;
  end

  assign hs    = |(req_valid & req_ready);
  assign issue = (state == BURST) && (!rsp_valid || rsp_ready);
  assign oor   = 32'(rom_addr) >= SIZE;

  // Burst FSM, ROM address generation and response slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      len_q     <= '0;
      beat      <= '0;
      rom_addr  <= '0;
      rom_vecop <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      // An accepted beat empties the slot unless a new beat overwrites it below
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (hs) begin
            rom_addr  <= req_addr[win];
            len_q     <= req_len[win];
            rom_vecop <= win;
            last_gnt  <= win;
            beat      <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            rsp_valid <= 1'b1;
            rsp_data  <= oor ? '0 : rom_rd;
            rsp_err   <= oor;
            rsp_id    <= rom_vecop;
            rsp_last  <= (beat == len_q);
            beat      <= beat + LW'(1);
            if (beat == len_q) begin
              state <= IDLE;
            end else begin
              rom_addr <= rom_addr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_RD_SCHED_PERF_EN
  // Grant and stall counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (hs && !win) perf_gnt0 <= perf_gnt0 + 32'd1;
      if (hs && win)  perf_gnt1 <= perf_gnt1 + 32'd1;
      if (rsp_valid && !rsp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_gnt0  = '0;
  assign perf_gnt1  = '0;
  assign perf_stall = '0;
`endif

endmodule
